// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 receiver pairing bytes into 16-bit words, high byte first.
// Optional RX_WORD_TIMEOUT_EN drops a stale half word after TIMEOUT_TICKS ticks.
module uart_word_rx #(
  parameter int DBIT          = 8,
  parameter int SB_TICK       = 16,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        baud_tick,
  input  logic        rx,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        frame_err,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t     state;
  logic [1:0] sync;
  logic       rxs;
  logic [3:0] s;
  logic [2:0] n;
  logic [7:0] b;
  logic [7:0] hi;
  logic       half;

  assign rxs = sync[1];

`ifdef RX_WORD_TIMEOUT_EN
  logic [15:0] tcnt;
  logic        to_q;
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk) begin
    if (!rst) sync <= 2'b11;
    else      sync <= {sync[0], rx};
  end

  // Frame FSM, word assembler and half-word timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      s          <= '0;
      n          <= '0;
      b          <= '0;
      hi         <= '0;
      half       <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef RX_WORD_TIMEOUT_EN
      tcnt       <= '0;
      to_q       <= 1'b0;
`endif
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef RX_WORD_TIMEOUT_EN
      to_q       <= 1'b0;
`endif
      if (baud_tick) begin
        unique case (state)
          IDLE: begin
            if (!rxs) begin
              state <= START;
              s     <= '0;
              busy  <= 1'b1;
            end
`ifdef RX_WORD_TIMEOUT_EN
            if (half) begin
              if (tcnt == 16'(TIMEOUT_TICKS - 1)) begin
                half <= 1'b0;
                to_q <= 1'b1;
                tcnt <= '0;
              end else begin
                tcnt <= tcnt + 16'd1;
              end
            end
`endif
          end
          START: begin
            if (s == 4'd7) begin
              if (!rxs) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
`ifdef RX_WORD_TIMEOUT_EN
                tcnt  <= '0;
`endif
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
          DATA: begin
            if (s == 4'd15) begin
              b <= {rxs, b[7:1]};
              s <= '0;
              if (n == 3'(DBIT - 1)) state <= STOP;
              else                   n     <= n + 3'd1;
            end else begin
              s <= s + 4'd1;
            end
          end
          STOP: begin
            if (s == 4'(SB_TICK - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              s     <= '0;
              if (rxs) begin
                if (half) begin
                  word_out   <= {hi, b};
                  word_valid <= 1'b1;
                  half       <= 1'b0;
`ifdef RX_WORD_TIMEOUT_EN
                  tcnt       <= '0;
`endif
                end else begin
                  hi   <= b;
                  half <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
                half      <= 1'b0;
`ifdef RX_WORD_TIMEOUT_EN
                tcnt      <= '0;
`endif
              end
            end else begin
              s <= s + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
